// File: rtl/rect_ctl_if.sv
// rect_ctl_if: groups the frame/handshake inputs and the position outputs of
// the rectangle position controller. The master side drives blanking, start
// and mouse; the slave side (rect_ctl) returns the rectangle position and busy.
interface rect_ctl_if;
    logic        vblnk;
    logic        start;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        busy;

    modport master (
        output vblnk, start, mouse_xpos, mouse_ypos,
        input  x_pos, y_pos, busy
    );

    modport slave (
        input  vblnk, start, mouse_xpos, mouse_ypos,
        output x_pos, y_pos, busy
    );
endinterface

// File: rtl/rect_ctl.sv
// rect_ctl: frame-rate position controller for the rectangle-drawing stage.
// Once per frame (rising edge of vblnk) it advances a bouncing-fall motion:
// gravity drop, damped floor rebound, horizontal drift reflecting at the
// side edges, and a stop once the rebound speed falls below REST_V.
// Optional feature macro: RECT_CTL_FOLLOW_EN -- when defined, IDLE tracks the
// (clamped) mouse position; when undefined, IDLE holds X_INIT/Y_INIT and the
// mouse inputs are ignored.
module rect_ctl #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int MAX_X      = 800,
    parameter int MAX_Y      = 600,
    parameter int X_INIT     = 0,
    parameter int Y_INIT     = 0,
    parameter int STEP_X     = 1,
    parameter int GRAVITY    = 1,
    parameter int V_MAX      = 31,
    parameter int DAMP_SHIFT = 2,
    parameter int REST_V     = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    rect_ctl_if.slave bus
);

    // Floor and right limit, widened to 13 bits so sums can overshoot
    // without wrapping before they are compared and clamped.
    localparam logic [12:0] FY13    = 13'(MAX_Y - HEIGHT);
    localparam logic [12:0] RX13    = 13'(MAX_X - WIDTH);
    localparam logic [11:0] FY12    = FY13[11:0];
    localparam logic [11:0] RX12    = RX13[11:0];
    localparam logic [12:0] STEP13  = 13'(STEP_X);
    localparam logic [11:0] STEP12  = STEP13[11:0];
    localparam logic [8:0]  GRAV9   = 9'(GRAVITY);
    localparam logic [8:0]  VMAX9   = 9'(V_MAX);
    localparam logic [7:0]  VMAX8   = VMAX9[7:0];
    localparam logic [7:0]  GRAV8   = 8'(GRAVITY);
    localparam logic [7:0]  REST8   = 8'(REST_V);
    localparam logic [11:0] XINIT12 = 12'(X_INIT);
    localparam logic [11:0] YINIT12 = 12'(Y_INIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        RISE = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t      state_q;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic [7:0]  vy_q;
    logic        xdir_q;
    logic        busy_q;
    logic        v1_q;
    logic        v2_q;

    logic        tick;
    logic [8:0]  vy_sum9;
    logic [7:0]  vy_fall_d;
    logic [7:0]  vy_damp_d;
    logic [7:0]  vy_rise_d;
    logic [12:0] y_fall13;
    logic [11:0] y_rise_d;
    logic        floor_hit;
    logic        apex;
    logic [12:0] x_right13;
    logic [11:0] x_move_d;
    logic        x_flip;
    logic [11:0] x_idle_d;
    logic [11:0] y_idle_d;
    logic [11:0] x_launch_d;
    logic [11:0] y_launch_d;

    // One frame tick per rising edge of the twice-registered blanking signal.
    assign tick = v1_q & ~v2_q;

    // Per-frame motion candidates: fall step with floor bounce, rise step
    // with apex detection, and horizontal drift with edge reflection.
    always_comb begin
        vy_sum9   = {1'b0, vy_q} + GRAV9;
        vy_fall_d = (vy_sum9 > VMAX9) ? VMAX8 : vy_sum9[7:0];
        y_fall13  = {1'b0, y_q} + {5'b0, vy_fall_d};
        floor_hit = (y_fall13 >= FY13);
        vy_damp_d = vy_fall_d - (vy_fall_d >> DAMP_SHIFT);
        apex      = (vy_q <= GRAV8);
        vy_rise_d = vy_q - GRAV8;
        y_rise_d  = (y_q < {4'b0, vy_rise_d}) ? 12'd0 : (y_q - {4'b0, vy_rise_d});
        x_right13 = {1'b0, x_q} + STEP13;
        if (!xdir_q) begin
            x_flip   = (x_right13 > RX13);
            x_move_d = x_flip ? RX12 : x_right13[11:0];
        end else begin
            x_flip   = ({1'b0, x_q} < STEP13);
            x_move_d = x_flip ? 12'd0 : (x_q - STEP12);
        end
    end

`ifdef RECT_CTL_FOLLOW_EN
    // Idle position follows the mouse, clamped so the rectangle stays on
    // screen; a launch starts from wherever the rectangle currently sits.
    always_comb begin
        x_idle_d   = ({1'b0, bus.mouse_xpos} > RX13) ? RX12 : bus.mouse_xpos;
        y_idle_d   = ({1'b0, bus.mouse_ypos} > FY13) ? FY12 : bus.mouse_ypos;
        x_launch_d = x_q;
        y_launch_d = y_q;
    end
`else
    logic unused_mouse;
    assign unused_mouse = ^{bus.mouse_xpos, bus.mouse_ypos};

    // Without mouse following the rectangle parks at, and launches from,
    // the init position even if it was just released from STOP.
    always_comb begin
        x_idle_d   = XINIT12;
        y_idle_d   = YINIT12;
        x_launch_d = XINIT12;
        y_launch_d = YINIT12;
    end
`endif

    // Controller FSM: blanking synchroniser, motion state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= XINIT12;
            y_q     <= YINIT12;
            vy_q    <= 8'd0;
            xdir_q  <= 1'b0;
            busy_q  <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
        end else begin
            v1_q <= bus.vblnk;
            v2_q <= v1_q;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q     <= x_launch_d;
                        y_q     <= y_launch_d;
                        vy_q    <= 8'd0;
                        xdir_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= FALL;
                    end else begin
                        x_q <= x_idle_d;
                        y_q <= y_idle_d;
                    end
                end
                FALL: begin
                    if (tick) begin
                        x_q <= x_move_d;
                        if (x_flip) begin
                            xdir_q <= ~xdir_q;
                        end
                        if (floor_hit) begin
                            y_q <= FY12;
                            if (vy_damp_d < REST8) begin
                                vy_q    <= 8'd0;
                                busy_q  <= 1'b0;
                                state_q <= STOP;
                            end else begin
                                vy_q    <= vy_damp_d;
                                state_q <= RISE;
                            end
                        end else begin
                            y_q  <= y_fall13[11:0];
                            vy_q <= vy_fall_d;
                        end
                    end
                end
                RISE: begin
                    if (tick) begin
                        x_q <= x_move_d;
                        if (x_flip) begin
                            xdir_q <= ~xdir_q;
                        end
                        if (apex) begin
                            vy_q    <= 8'd0;
                            state_q <= FALL;
                        end else begin
                            vy_q <= vy_rise_d;
                            y_q  <= y_rise_d;
                        end
                    end
                end
                STOP: begin
                    if (bus.start) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.x_pos = x_q;
    assign bus.y_pos = y_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rect_ctl.sv
// tb_rect_ctl: randomized self-checking bench for rect_ctl. Two instances run
// side by side: one with default parameters and one with a small screen, a
// coarse step and stronger damping so edge reflections happen within a flight.
// A frame-level reference model predicts the position after every frame.
module tb_rect_ctl;

    localparam int M_IDLE = 0;
    localparam int M_FALL = 1;
    localparam int M_RISE = 2;
    localparam int M_STOP = 3;
    localparam int MAX_FRAMES = 3000;

    localparam int D1_WIDTH = 64,  D1_HEIGHT = 20, D1_MAX_X = 100, D1_MAX_Y = 120;
    localparam int D1_XI = 10, D1_YI = 20, D1_STEP = 7, D1_G = 2;
    localparam int D1_VMAX = 15, D1_DS = 1, D1_REST = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rect_ctl_if bus0 ();
    rect_ctl_if bus1 ();

    rect_ctl u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    rect_ctl #(
        .WIDTH(D1_WIDTH), .HEIGHT(D1_HEIGHT), .MAX_X(D1_MAX_X), .MAX_Y(D1_MAX_Y),
        .X_INIT(D1_XI), .Y_INIT(D1_YI), .STEP_X(D1_STEP), .GRAVITY(D1_G),
        .V_MAX(D1_VMAX), .DAMP_SHIFT(D1_DS), .REST_V(D1_REST)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    int p_rx[2], p_fy[2], p_step[2], p_g[2], p_vmax[2], p_ds[2], p_rest[2], p_xi[2], p_yi[2];
    int mx[2], my[2], mvy[2], mdir[2], mmode[2];
    int cur_mx, cur_my;
    int n_cmp, n_err;
    logic [11:0] ox[2], oy[2];
    logic        ob[2];

    // Model parameters mirror each instance's parameter set.
    task automatic init_params();
        p_rx[0] = 800 - 64;  p_fy[0] = 600 - 64; p_step[0] = 1; p_g[0] = 1;
        p_vmax[0] = 31; p_ds[0] = 2; p_rest[0] = 2; p_xi[0] = 0; p_yi[0] = 0;
        p_rx[1] = D1_MAX_X - D1_WIDTH; p_fy[1] = D1_MAX_Y - D1_HEIGHT; p_step[1] = D1_STEP;
        p_g[1] = D1_G; p_vmax[1] = D1_VMAX; p_ds[1] = D1_DS; p_rest[1] = D1_REST;
        p_xi[1] = D1_XI; p_yi[1] = D1_YI;
    endtask

    function automatic int idle_x(input int i, input int m);
`ifdef RECT_CTL_FOLLOW_EN
        return (m > p_rx[i]) ? p_rx[i] : m;
`else
        return p_xi[i] + 0 * m;
`endif
    endfunction

    function automatic int idle_y(input int i, input int m);
`ifdef RECT_CTL_FOLLOW_EN
        return (m > p_fy[i]) ? p_fy[i] : m;
`else
        return p_yi[i] + 0 * m;
`endif
    endfunction

    function automatic logic exp_busy(input int i);
        return (mmode[i] == M_FALL || mmode[i] == M_RISE);
    endfunction

    function automatic void model_reset(input int i);
        mx[i] = p_xi[i]; my[i] = p_yi[i]; mvy[i] = 0; mdir[i] = 0; mmode[i] = M_IDLE;
    endfunction

    function automatic void model_idle(input int i);
        mx[i] = idle_x(i, cur_mx); my[i] = idle_y(i, cur_my);
    endfunction

    function automatic void model_start(input int i);
        model_idle(i); mvy[i] = 0; mdir[i] = 0; mmode[i] = M_FALL;
    endfunction

    // One frame of motion, straight from the motion rules.
    function automatic void model_tick(input int i);
        int d;
        if (mmode[i] == M_FALL || mmode[i] == M_RISE) begin
            if (mdir[i] == 0) begin
                if (mx[i] + p_step[i] > p_rx[i]) begin mx[i] = p_rx[i]; mdir[i] = 1; end
                else mx[i] = mx[i] + p_step[i];
            end else begin
                if (mx[i] < p_step[i]) begin mx[i] = 0; mdir[i] = 0; end
                else mx[i] = mx[i] - p_step[i];
            end
            if (mmode[i] == M_FALL) begin
                mvy[i] = (mvy[i] + p_g[i] > p_vmax[i]) ? p_vmax[i] : mvy[i] + p_g[i];
                if (my[i] + mvy[i] >= p_fy[i]) begin
                    my[i] = p_fy[i];
                    d = mvy[i] - mvy[i] / (1 << p_ds[i]);
                    if (d < p_rest[i]) begin mvy[i] = 0; mmode[i] = M_STOP; end
                    else begin mvy[i] = d; mmode[i] = M_RISE; end
                end else begin
                    my[i] = my[i] + mvy[i];
                end
            end else begin
                if (mvy[i] <= p_g[i]) begin
                    mvy[i] = 0; mmode[i] = M_FALL;
                end else begin
                    mvy[i] = mvy[i] - p_g[i];
                    my[i] = (my[i] - mvy[i] < 0) ? 0 : my[i] - mvy[i];
                end
            end
        end
    endfunction

    function automatic void sample();
        ox[0] = bus0.x_pos; oy[0] = bus0.y_pos; ob[0] = bus0.busy;
        ox[1] = bus1.x_pos; oy[1] = bus1.y_pos; ob[1] = bus1.busy;
    endfunction

    // Drives all inputs, then advances to just after the next rising edge.
    task automatic applyStimulus(input logic vb, input logic s0, input logic s1,
                                 input int nx, input int ny);
        bus0.vblnk = vb; bus1.vblnk = vb;
        bus0.start = s0; bus1.start = s1;
        bus0.mouse_xpos = 12'(nx); bus1.mouse_xpos = 12'(nx);
        bus0.mouse_ypos = 12'(ny); bus1.mouse_ypos = 12'(ny);
        cur_mx = nx; cur_my = ny;
        @(posedge clk);
        #1;
    endtask

    // One video frame: vblnk high for 2+hold clocks, then low; the position
    // must move only on the second clock of the high phase.
    task automatic run_frame(input logic scramble);
        int hold, low;
        string tag;
        logic s0, s1;
        hold = $urandom_range(0, 3);
        low  = $urandom_range(1, 4);
        for (int ph = 0; ph < 2 + hold; ph++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, cur_mx, cur_my);
            if (ph == 1) begin
                model_tick(0); model_tick(1);
            end
            tag = (ph == 0) ? "vblnk_sampled" : (ph == 1) ? "frame_update" : "vblnk_held";
            sample();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (ox[i] !== 12'(mx[i]) || oy[i] !== 12'(my[i]) || ob[i] !== exp_busy(i)) begin
                    n_err++;
                    $display("[TB] FAIL %s dut%0d: got (%0d,%0d,busy=%0d) expected (%0d,%0d,busy=%0d)",
                             tag, i, ox[i], oy[i], ob[i], mx[i], my[i], exp_busy(i));
                end
            end
        end
        for (int k = 0; k < low; k++) begin
            s0 = exp_busy(0) && ($urandom_range(0, 3) == 0);
            s1 = exp_busy(1) && ($urandom_range(0, 3) == 0);
            if (scramble)
                applyStimulus(1'b0, s0, s1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            else
                applyStimulus(1'b0, s0, s1, cur_mx, cur_my);
        end
    endtask

    // Start pulse to both instances, optionally on the same clock as a tick.
    task automatic launch(input int coincide);
        if (coincide != 0) applyStimulus(1'b1, 1'b0, 1'b0, cur_mx, cur_my);
        applyStimulus(coincide != 0, 1'b1, 1'b1, cur_mx, cur_my);
        model_start(0); model_start(1);
        applyStimulus(1'b0, 1'b0, 1'b0, cur_mx, cur_my);
        sample();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ox[i] !== 12'(mx[i]) || oy[i] !== 12'(my[i]) || ob[i] !== exp_busy(i)) begin
                n_err++;
                $display("[TB] FAIL launch dut%0d: got (%0d,%0d,busy=%0d) expected (%0d,%0d,busy=%0d)",
                         i, ox[i], oy[i], ob[i], mx[i], my[i], exp_busy(i));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        #3 rst_n = 1'b1;
        model_reset(0); model_reset(1);
        model_idle(0); model_idle(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        launch(0);
        repeat (5) run_frame(1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset(0); model_reset(1);
        sample();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ox[i] !== 12'(mx[i]) || oy[i] !== 12'(my[i]) || ob[i] !== exp_busy(i)) begin
                n_err++;
                $display("[TB] FAIL async_reset dut%0d: got (%0d,%0d,busy=%0d) expected (%0d,%0d,busy=%0d)",
                         i, ox[i], oy[i], ob[i], mx[i], my[i], exp_busy(i));
            end
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        model_idle(0); model_idle(1);
        repeat (3) run_frame(1'b0);
    endtask

    task automatic test_follow();
        int xs[8], ys[8];
        xs[0] = 900; ys[0] = 700; xs[1] = 100; ys[1] = 50;
        xs[2] = 736; ys[2] = 536; xs[3] = 737; ys[3] = 537;
        xs[4] = 4095; ys[4] = 4095;
        for (int k = 5; k < 8; k++) begin
            xs[k] = $urandom_range(0, 1023); ys[k] = $urandom_range(0, 1023);
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, xs[k], ys[k]);
            model_idle(0); model_idle(1);
            sample();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if (ox[i] !== 12'(mx[i]) || oy[i] !== 12'(my[i]) || ob[i] !== exp_busy(i)) begin
                    n_err++;
                    $display("[TB] FAIL follow dut%0d mouse=(%0d,%0d): got (%0d,%0d,busy=%0d) expected (%0d,%0d,busy=%0d)",
                             i, xs[k], ys[k], ox[i], oy[i], ob[i], mx[i], my[i], exp_busy(i));
                end
            end
        end
    endtask

    task automatic test_flight(input int sx, input int sy);
        int frames;
        applyStimulus(1'b0, 1'b0, 1'b0, sx, sy);
        applyStimulus(1'b0, 1'b0, 1'b0, sx, sy);
        model_idle(0); model_idle(1);
        launch($urandom_range(0, 1));
        frames = 0;
        while ((exp_busy(0) || exp_busy(1)) && frames < MAX_FRAMES) begin
            run_frame(1'b1);
            frames++;
        end
        n_cmp++;
        if (frames >= MAX_FRAMES) begin
            n_err++;
            $display("[TB] FAIL flight_timeout: got %0d frames without stop, required fewer than %0d",
                     frames, MAX_FRAMES);
        end
        repeat (2) run_frame(1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, cur_mx, cur_my);
        mmode[0] = M_IDLE; mmode[1] = M_IDLE;
        sample();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ox[i] !== 12'(mx[i]) || oy[i] !== 12'(my[i]) || ob[i] !== exp_busy(i)) begin
                n_err++;
                $display("[TB] FAIL stop_to_idle dut%0d: got (%0d,%0d,busy=%0d) expected (%0d,%0d,busy=%0d)",
                         i, ox[i], oy[i], ob[i], mx[i], my[i], exp_busy(i));
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, cur_mx, cur_my);
        model_idle(0); model_idle(1);
        sample();
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ox[i] !== 12'(mx[i]) || oy[i] !== 12'(my[i]) || ob[i] !== exp_busy(i)) begin
                n_err++;
                $display("[TB] FAIL idle_resume dut%0d: got (%0d,%0d,busy=%0d) expected (%0d,%0d,busy=%0d)",
                         i, ox[i], oy[i], ob[i], mx[i], my[i], exp_busy(i));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus0.vblnk = 1'b0; bus1.vblnk = 1'b0;
        bus0.start = 1'b0; bus1.start = 1'b0;
        bus0.mouse_xpos = '0; bus1.mouse_xpos = '0;
        bus0.mouse_ypos = '0; bus1.mouse_ypos = '0;
        cur_mx = 0; cur_my = 0;
        init_params();
        test_reset();
        test_follow();
        test_flight(0, 0);
        test_flight(0, 530);
        test_flight(0, 535);
        test_flight(735, 100);
        test_flight(int'($urandom_range(0, 900)), int'($urandom_range(0, 700)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before the sequence completed");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
